// File: rtl/vscpu_timer_irq.sv
// Memory-mapped down-counting timer with level interrupt, on the CPU RAM bus.
// Optional prescaler (offset 4) is built when VSCPU_TIMER_PRESCALE_EN is defined.
module vscpu_timer_irq #(
  parameter logic [13:0] BASE_ADDR = 14'h3FF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic [13:0] addr_toRAM,
  input  logic [31:0] data_toRAM,
  output logic [31:0] data_fromTimer,
  output logic        hit,
  output logic        interrupt
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;

  logic        sel;
  logic [2:0]  off;
  logic        wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
  logic        en, reload, ie, pend;
  logic [31:0] load, count;
  logic        tick, expire;
  logic [31:0] rd_data;

  assign sel       = (addr_toRAM[13:3] == BASE_ADDR[13:3]);
  assign off       = addr_toRAM[2:0];
  assign wr_ctrl   = wrEn && sel && (off == OFF_CTRL);
  assign wr_load   = wrEn && sel && (off == OFF_LOAD);
  assign wr_count  = wrEn && sel && (off == OFF_COUNT);
  assign wr_status = wrEn && sel && (off == OFF_STATUS);
  assign wr_presc  = wrEn && sel && (off == OFF_PRESC);

`ifdef VSCPU_TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] div;

  assign tick = en && (div == prescale);

  // Divider restarts whenever the count is re-armed so the first period is full length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= '0;
      div      <= '0;
    end else begin
      if (wr_presc) prescale <= data_toRAM[15:0];
      if (!en || wr_presc || wr_count || tick) div <= '0;
      else                                     div <= div + 16'd1;
    end
  end
`else
  assign tick = en;
`endif

  assign expire    = tick && (count == 32'd0);
  assign interrupt = pend && ie;

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CTRL:   rd_data = {29'd0, ie, reload, en};
      OFF_LOAD:   rd_data = load;
      OFF_COUNT:  rd_data = count;
      OFF_STATUS: rd_data = {31'd0, pend};
`ifdef VSCPU_TIMER_PRESCALE_EN
      OFF_PRESC:  rd_data = {16'd0, prescale};
`endif
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en             <= 1'b0;
      reload         <= 1'b0;
      ie             <= 1'b0;
      load           <= '0;
      count          <= '0;
      pend           <= 1'b0;
      data_fromTimer <= '0;
      hit            <= 1'b0;
    end else begin
      if (wr_load) load <= data_toRAM;

      // A bus write to CTRL wins over the one-shot self-disable.
      if (wr_ctrl) begin
        en     <= data_toRAM[0];
        reload <= data_toRAM[1];
        ie     <= data_toRAM[2];
      end else if (expire && !reload) begin
        en <= 1'b0;
      end

      if (wr_count) begin
        count <= data_toRAM;
      end else if (tick) begin
        if (count != 32'd0) count <= count - 32'd1;
        else if (reload)    count <= load;
      end

      // Expiry set beats a coincident write-1-clear.
      if (expire)                        pend <= 1'b1;
      else if (wr_status && data_toRAM[0]) pend <= 1'b0;

      data_fromTimer <= sel ? rd_data : 32'd0;
      hit            <= sel;
    end
  end

endmodule

// File: tb/tb_vscpu_timer_irq.sv
// Directed self-checking bench for vscpu_timer_irq; covers the prescaler
// path as well when VSCPU_TIMER_PRESCALE_EN is defined.
module tb_vscpu_timer_irq;

  localparam logic [13:0] BASE = 14'h3FF0;
  localparam logic [13:0] IDLE = 14'h0000;

  logic        clk;
  logic        rst;
  logic        wrEn;
  logic [13:0] addr_toRAM;
  logic [31:0] data_toRAM;
  logic [31:0] data_fromTimer;
  logic        hit;
  logic        interrupt;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];

  vscpu_timer_irq #(.BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .wrEn           (wrEn),
    .addr_toRAM     (addr_toRAM),
    .data_toRAM     (data_toRAM),
    .data_fromTimer (data_fromTimer),
    .hit            (hit),
    .interrupt      (interrupt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic bus_write_addr(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    wrEn = 1'b1; addr_toRAM = a; data_toRAM = d;
    @(posedge clk); #1;
    wrEn = 1'b0; addr_toRAM = IDLE; data_toRAM = '0;
  endtask

  task automatic bus_write(input logic [2:0] o, input logic [31:0] d);
    bus_write_addr(BASE + {11'd0, o}, d);
  endtask

  task automatic bus_read_addr(input logic [13:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    wrEn = 1'b0; addr_toRAM = a;
    @(posedge clk); #1;
    d = data_fromTimer; h = hit;
    addr_toRAM = IDLE;
  endtask

  task automatic bus_read(input logic [2:0] o, output logic [31:0] d);
    logic h;
    bus_read_addr(BASE + {11'd0, o}, d, h);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic h;
    rst = 1'b0; wrEn = 1'b1; addr_toRAM = BASE; data_toRAM = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (data_fromTimer !== 32'd0) begin
      $display("FAIL reset_data: got %0h expected 0", data_fromTimer); tests_failed++;
    end
    tests_run++;
    if (hit !== 1'b0) begin
      $display("FAIL reset_hit: got %0b expected 0", hit); tests_failed++;
    end
    tests_run++;
    if (interrupt !== 1'b0) begin
      $display("FAIL reset_irq: got %0b expected 0", interrupt); tests_failed++;
    end
    @(negedge clk);
    rst = 1'b1; wrEn = 1'b0; addr_toRAM = IDLE; data_toRAM = '0;
    for (int i = 0; i < 8; i++) begin
      bus_read_addr(BASE + 14'(i), d, h);
      tests_run++;
      if (d !== 32'd0 || h !== 1'b1 || interrupt !== 1'b0) begin
        $display("FAIL reset_read[%0d]: got data=%0h hit=%0b irq=%0b expected 0/1/0", i, d, h, interrupt);
        tests_failed++;
      end
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'd3);
    bus_write(3'd0, 32'd5);
    tests_run++;
    if (interrupt !== 1'b0) begin
      $display("FAIL oneshot_irq_start: got %0b expected 0", interrupt); tests_failed++;
    end
    for (int k = 1; k <= 4; k++) begin
      idle_cycle();
      tests_run++;
      if (interrupt !== (k == 4)) begin
        $display("FAIL oneshot_irq_edge%0d: got %0b expected %0b", k, interrupt, (k == 4)); tests_failed++;
      end
    end
    bus_read(3'd0, d);
    tests_run++;
    if (d !== 32'd4) begin
      $display("FAIL oneshot_ctrl: got %0h expected 4", d); tests_failed++;
    end
    bus_read(3'd2, d);
    tests_run++;
    if (d !== 32'd0) begin
      $display("FAIL oneshot_count: got %0h expected 0", d); tests_failed++;
    end
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd1) begin
      $display("FAIL oneshot_status: got %0h expected 1", d); tests_failed++;
    end
    bus_write(3'd3, 32'd1);
    tests_run++;
    if (interrupt !== 1'b0) begin
      $display("FAIL oneshot_clear: got %0b expected 0", interrupt); tests_failed++;
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    logic [31:0] e;
    bus_write(3'd1, 32'd2);
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'd7);
    exp_q = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd2};
    for (int i = 0; i < 5; i++) begin
      bus_read(3'd2, d);
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e) begin
        $display("FAIL reload_count[%0d]: got %0h expected %0h", i, d, e); tests_failed++;
      end
      if (i == 0) begin
        tests_run++;
        if (interrupt !== 1'b1) begin
          $display("FAIL reload_first_tick_irq: got %0b expected 1", interrupt); tests_failed++;
        end
      end
    end
    bus_write(3'd3, 32'd1);
    tests_run++;
    if (interrupt !== 1'b0) begin
      $display("FAIL reload_clear_irq: got %0b expected 0", interrupt); tests_failed++;
    end
  endtask

  task automatic test_expiry_collisions();
    logic [31:0] d;
    bus_write(3'd0, 32'd0);
    bus_write(3'd3, 32'd1);
    bus_write(3'd1, 32'd2);
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'd7);
    // next edge is an expiry: clear collides with set
    bus_write(3'd3, 32'd1);
    tests_run++;
    if (interrupt !== 1'b1) begin
      $display("FAIL clear_on_expiry: got %0b expected 1", interrupt); tests_failed++;
    end
    bus_write(3'd3, 32'd1);
    tests_run++;
    if (interrupt !== 1'b0) begin
      $display("FAIL clear_off_expiry: got %0b expected 0", interrupt); tests_failed++;
    end
    idle_cycle();
    bus_write(3'd2, 32'd10);
    tests_run++;
    if (interrupt !== 1'b1) begin
      $display("FAIL count_write_on_expiry_irq: got %0b expected 1", interrupt); tests_failed++;
    end
    bus_read(3'd2, d);
    tests_run++;
    if (d !== 32'd10) begin
      $display("FAIL count_write_on_expiry: got %0h expected a", d); tests_failed++;
    end
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd1) begin
      $display("FAIL count_write_on_expiry_pend: got %0h expected 1", d); tests_failed++;
    end
    bus_write(3'd0, 32'd0);
  endtask

  task automatic test_window();
    logic [31:0] d;
    logic h;
    logic [31:0] e;
    bus_write(3'd0, 32'd0);
    bus_write(3'd3, 32'd1);
    bus_write(3'd1, 32'h0000_ABCD);
    bus_write(3'd2, 32'h0000_1234);
    bus_read_addr(BASE + 14'd8, d, h);
    tests_run++;
    if (d !== 32'd0 || h !== 1'b0) begin
      $display("FAIL window_base_plus8: got data=%0h hit=%0b expected 0/0", d, h); tests_failed++;
    end
    bus_read_addr(14'h000A, d, h);
    tests_run++;
    if (d !== 32'd0 || h !== 1'b0) begin
      $display("FAIL window_000a: got data=%0h hit=%0b expected 0/0", d, h); tests_failed++;
    end
    bus_write_addr(BASE + 14'd5, 32'hFFFF_FFFF);
    bus_write_addr(14'h3FE1, 32'h5555_5555);
    bus_write_addr(BASE + 14'd10, 32'h6666_6666);
    exp_q = '{32'd0, 32'h0000_ABCD, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), d);
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e) begin
        $display("FAIL window_reg[%0d]: got %0h expected %0h", i, d, e); tests_failed++;
      end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic [31:0] e;
    int n;
`ifdef VSCPU_TIMER_PRESCALE_EN
    bus_write(3'd4, 32'd1);
    bus_write(3'd2, 32'd2);
    bus_write(3'd0, 32'd1);
    exp_q = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};
`else
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_read(3'd4, d);
    tests_run++;
    if (d !== 32'd0) begin
      $display("FAIL prescale_absent_read: got %0h expected 0", d); tests_failed++;
    end
    bus_write(3'd2, 32'd2);
    bus_write(3'd0, 32'd1);
    exp_q = '{32'd2, 32'd1, 32'd0};
`endif
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      bus_read(3'd2, d);
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e) begin
        $display("FAIL prescale_count[%0d]: got %0h expected %0h", i, d, e); tests_failed++;
      end
    end
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd1) begin
      $display("FAIL prescale_pend: got %0h expected 1", d); tests_failed++;
    end
    bus_read(3'd0, d);
    tests_run++;
    if (d !== 32'd0) begin
      $display("FAIL prescale_ctrl_after: got %0h expected 0", d); tests_failed++;
    end
`ifdef VSCPU_TIMER_PRESCALE_EN
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_read(3'd4, d);
    tests_run++;
    if (d !== 32'h0000_FFFF) begin
      $display("FAIL prescale_readback: got %0h expected ffff", d); tests_failed++;
    end
    bus_write(3'd4, 32'd0);
`endif
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    bus_write(3'd3, 32'd1);
    bus_write(3'd1, 32'd5);
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'd7);
    idle_cycle();
    tests_run++;
    if (interrupt !== 1'b1) begin
      $display("FAIL midreset_pre_irq: got %0b expected 1", interrupt); tests_failed++;
    end
    @(negedge clk);
    rst = 1'b0; addr_toRAM = BASE + 14'd2;
    @(posedge clk); #1;
    tests_run++;
    if (interrupt !== 1'b0 || hit !== 1'b0 || data_fromTimer !== 32'd0) begin
      $display("FAIL midreset_outputs: got irq=%0b hit=%0b data=%0h expected 0/0/0", interrupt, hit, data_fromTimer);
      tests_failed++;
    end
    @(negedge clk);
    rst = 1'b1; addr_toRAM = IDLE;
    for (int i = 0; i < 5; i++) begin
      bus_read(3'(i), d);
      tests_run++;
      if (d !== 32'd0) begin
        $display("FAIL midreset_reg[%0d]: got %0h expected 0", i, d); tests_failed++;
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0; wrEn = 1'b0; addr_toRAM = IDLE; data_toRAM = '0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_expiry_collisions();
    test_window();
    test_prescale();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vscpu_timer_irq.md
# vscpu_timer_irq

Memory-mapped down-counting timer and interrupt source that sits on the CPU's RAM bus beside the block RAM. It responds to CPU reads and writes inside an 8-word address window, with the same one-cycle registered read latency as the block RAM. It drives the CPU `interrupt` input when the count expires. It is the responder and interrupt-source end of the CPU's memory/interrupt interface.

## Interface
- `BASE_ADDR`, 14'h3FF0, word address of register window; bits [2:0] must be 0.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  synchronous reset, active-low.
- `wrEn`  input  1  CPU write strobe.
- `addr_toRAM`  input  14  CPU word address.
- `data_toRAM`  input  32  CPU write data.
- `data_fromTimer`  output  32  registered read data.
- `hit`  output  1  registered; 1 when `data_fromTimer` holds a valid window read. The external mux selects the timer over RAM with it.
- `interrupt`  output  1  level interrupt to the CPU.

## Operation
- Window decode: `sel = addr_toRAM[13:3] == BASE_ADDR[13:3]`. Offset is `addr_toRAM[2:0]`.
- Registers:
  - 0 CTRL: bit0 EN, bit1 RELOAD, bit2 IE. Other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: 32-bit current count, R/W.
  - 3 STATUS: bit0 PEND. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 4 PRESCALE: see Configuration.
  - 5–7 read 0; writes ignored.
- Read: every cycle, `data_fromTimer <= sel ? reg[offset] : 0` and `hit <= sel`. A read returns the register value from before any same-cycle write.
- Write: on `wrEn && sel`, the addressed register updates at the next edge.
- Count tick, when EN=1 and the tick is enabled:
  - COUNT != 0: `COUNT <= COUNT - 1`.
  - COUNT == 0 (expiry): PEND <= 1. If RELOAD, `COUNT <= LOAD`; otherwise EN <= 0 and COUNT stays 0.
- `interrupt = PEND & IE`. This is combinational from registers, so it is glitch-free.
- Priorities in the same cycle:
  - A bus write to COUNT overrides the tick and expiry reload. Expiry still sets PEND if COUNT was 0.
  - A bus write to CTRL overrides the EN clear from one-shot expiry.
  - STATUS write-1-clear coinciding with expiry leaves PEND = 1 (the set wins).
- Arithmetic is unsigned 32-bit. There is no underflow wrap past 0.

## Timing
- Reset (rst=0 at an edge) sets CTRL, LOAD, COUNT, STATUS and PRESCALE to 0, and sets `data_fromTimer`=0, `hit`=0, `interrupt`=0. Reset overrides any write in the same cycle.
- Read latency is 1 cycle: the address is presented in cycle N and the data is valid after edge N+1.
- Write latency is 1 cycle. Counting starts on the edge after EN is written.
- With prescale 0, a LOAD of L in one-shot mode asserts PEND at edge L+1 after counting starts, because the COUNT=0 cycle is itself a tick.
- Reset mid-count aborts the count immediately. No pending interrupt survives reset.

## Configuration
- `VSCPU_TIMER_PRESCALE_EN` defined:
  - Offset 4 is a 16-bit PRESCALE register (bits [31:16] read 0).
  - An internal 16-bit divider counts 0..PRESCALE while EN=1.
  - A tick occurs when the divider equals PRESCALE; the divider then returns to 0.
  - The divider clears when EN=0, on reset, and on any write to PRESCALE or COUNT.
  - PRESCALE=0 gives a tick every cycle.
- `VSCPU_TIMER_PRESCALE_EN` undefined:
  - Offset 4 reads 0 and ignores writes.
  - A tick occurs every cycle while EN=1.
  - No divider logic is present.

## Test plan
- Reset with rst=0 for 2 cycles, then read offsets 0–7 -> all return 0, `hit`=1 each read, `interrupt`=0.
- Write LOAD=3, COUNT=3, CTRL=5 (EN, IE, one-shot) -> PEND and `interrupt` rise 4 cycles after the CTRL write edge; CTRL reads 4 (EN cleared); COUNT reads 0.
- Auto-reload: LOAD=2, COUNT=0, CTRL=7 -> PEND sets on the first tick and COUNT sequence reads 2,1,0,2. Write STATUS=1 -> `interrupt` drops the next cycle.
- Write STATUS=1 on the exact expiry cycle -> PEND remains 1. Write COUNT=10 on the expiry cycle -> COUNT=10, PEND=1.
- Out-of-window: read address `BASE_ADDR`+8 and 14'h000A -> `hit`=0, `data_fromTimer`=0. A write to `BASE_ADDR`+5 leaves all registers unchanged.
- With the macro defined: PRESCALE=1, COUNT=2, CTRL=1 -> COUNT decrements every 2 cycles and PEND sets after 6 cycles. Assert rst=0 mid-count -> all state 0 next edge.
